test_mux_sched: RTL and testbench
=================================

// Module: test_mux_sched
// PURPOSE
// - Sequences select writes into the 8-lane test-signal mux bank (8 lanes x 8 bits, 64 sources of 8 bits).
// - Holds a shadow table of per-lane source indices and commits it to the mux on APPLY, one lane per enabled cycle.
// - Optional auto-scan rotates all lanes through the 64 sources periodically, so the scope sweeps every group unattended.
// - Sits between the IO register decode and the mux bank; replaces the software writes of select indices one by one.
// PARAMETERS
// - CLanes     8   number of mux lanes (select write-enable width)
// - CIdxW      6   source index width (64 sources)
// - CTimerW    16  scan period counter width
// - CScanStep  8   offset added to every lane per scan tick, modulo 2^CIdxW
// PORTS
// - AClkH       in   1               clock
// - AResetH     in   1               synchronous reset, active-high
// - AClkHEn     in   1               clock enable; state advances only when 1
// - ACfgWrEn    in   1               write shadow entry ACfgAddr <= ACfgData
// - ACfgAddr    in   3               shadow lane index
// - ACfgData    in   CIdxW           source index for that lane
// - AApply      in   1               single-cycle request: commit shadow table, offset := 0
// - AScanEn     in   1               level: auto-scan enable
// - AScanPeriod in   CTimerW         enabled cycles between scan ticks; 0 = scan disabled
// - ASelIdx     out  CIdxW           index driven to all lanes
// - ASelWrEn    out  CLanes          one-hot lane write strobe
// - AActiveIdx  out  CLanes*CIdxW    committed index per lane, lane0 in LSBs (readback for the PC plot)
// - ABusy       out  1               load sequence in progress
// - ADone       out  1               1-cycle pulse after the last lane is written
// BEHAVIOUR
// - Reset dominates AClkHEn. All outputs 0, shadow = 0, offset = 0, timer = 0, FSM = IDLE, pending = 0.
// - With AClkHEn=0, all registers hold. Strobes are registered, so ASelWrEn/ADone are gated to 0 during hold.
// - Shadow write: takes effect on the enabled edge, in any FSM state.
// - FSM states:
//   - IDLE: on a load start, snapshot shadow into the load buffer, lane := 0, go to LOAD.
//   - LOAD: each enabled cycle:
//     - ASelWrEn = 1 << lane.
//     - ASelIdx = (snap[lane] + offset) mod 64.
//     - AActiveIdx[lane] is updated with the same value.
//     - lane++.
//     - After lane 7 go to DONE.
//   - DONE: ADone=1 for one cycle. If pending is set, clear it, re-snapshot and go to LOAD. Otherwise go to IDLE.
// - Load start:
//   - AApply: offset := 0.
//   - Scan tick: offset := (offset + CScanStep) mod 64.
//   - Offset wraps 56 -> 0.
// - Latency: AApply in cycle N (IDLE) gives lane0 strobe in N+1, lane7 in N+8, ADone in N+9.
// - ABusy = 1 from N+1 through N+9 inclusive.
// - Scan timer:
//   - Counts only when AScanEn=1, AScanPeriod!=0 and FSM=IDLE.
//   - Tick when count == AScanPeriod-1, then count := 0.
//   - Deasserting AScanEn clears the count. Offset holds.
// - Simultaneous events:
//   - AApply and scan tick in the same cycle: AApply wins, offset := 0, timer cleared.
//   - AApply during LOAD/DONE: sets pending (one-deep; extra requests merge). It is served with offset := 0 right after DONE.
//   - A scan tick cannot occur outside IDLE (timer frozen).
//   - ACfgWrEn during LOAD does not affect the current sequence (snapshot). It is visible at the next load.
// - Reset mid-LOAD: the sequence aborts, AActiveIdx = 0. The mux bank holds old values until the next APPLY.
// STRUCTURE
// - Package test_mux_pkg:
//   - CLanes, CIdxW, CScanStep.
//   - FSM state enum {IDLE, LOAD, DONE} (2 bits).
//   - Function lane_onehot(idx).
// - Sub-module test_mux_scan_timer (CTimerW): inputs en, period, clr; output tick. It holds the period counter and tick compare.
// - Top: shadow regfile, snapshot buffer, FSM, lane counter, offset, pending flag, AActiveIdx regs.
// TESTING
// - Reset, shadow = {7,6,5,4,3,2,1,0}, AApply @N -> ASelWrEn 01,02..80 @N+1..N+8; ASelIdx 0..7; ADone @N+9; AActiveIdx = same.
// - AScanEn=1, AScanPeriod=4 after apply -> tick every 4 idle cycles + 9-cycle load; lane0 idx 8,16,..,56,0 (wrap).
// - AApply at lane 3 of a load -> sequence finishes; ADone; immediate second load with offset 0; exactly one extra load.
// - ACfgWrEn lane5=63 during LOAD -> current load writes old lane5; next APPLY writes 63; offset 8 scan -> (63+8)%64=7.
// - AClkHEn toggling 1/0 during LOAD -> each lane strobed exactly once, 8 strobes total, no strobe while enable = 0.
// - AResetH asserted at lane 4 -> next cycle all outputs 0, FSM IDLE; AScanPeriod=0 with AScanEn=1 -> no ticks.

Source files
------------

// File: rtl/test_mux_pkg.sv
// Shared constants, FSM state encoding and lane strobe helper for the
// test-signal mux select sequencer.
package test_mux_pkg;

    localparam int CLanes    = 8;
    localparam int CIdxW     = 6;
    localparam int CScanStep = 8;
    localparam int CLaneW    = $clog2(CLanes);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [CLanes-1:0] lane_onehot(input logic [CLaneW-1:0] idx);
        return CLanes'(1) << idx;
    endfunction

endpackage

// File: rtl/test_mux_scan_timer.sv
// Auto-scan period counter: ticks once every period_i enabled cycles.
// The caller folds its clock enable into en_i and clr_i, so both low means hold.
module test_mux_scan_timer #(
    parameter int CTimerW = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [CTimerW-1:0] period_i,
    input  logic               clr_i,
    output logic               tick_o
);

    logic [CTimerW-1:0] count_q, count_d;
    logic               period_ok;

    assign period_ok = (period_i != '0);
    assign tick_o    = en_i && period_ok && (count_q == period_i - CTimerW'(1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && period_ok) begin
            count_d = tick_o ? '0 : count_q + CTimerW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/test_mux_sched.sv
// Select-write sequencer for the 8-lane test mux bank: shadow table, snapshot
// load FSM, scan offset and per-lane committed index readback.
module test_mux_sched
    import test_mux_pkg::*;
#(
    parameter int CTimerW = 16
) (
    input  logic                    AClkH,
    input  logic                    AResetH,
    input  logic                    AClkHEn,
    input  logic                    ACfgWrEn,
    input  logic [CLaneW-1:0]       ACfgAddr,
    input  logic [CIdxW-1:0]        ACfgData,
    input  logic                    AApply,
    input  logic                    AScanEn,
    input  logic [CTimerW-1:0]      AScanPeriod,
    output logic [CIdxW-1:0]        ASelIdx,
    output logic [CLanes-1:0]       ASelWrEn,
    output logic [CLanes*CIdxW-1:0] AActiveIdx,
    output logic                    ABusy,
    output logic                    ADone,
    output state_e                  ADbgState
);

    state_e                         state_q, state_d;
    logic [CLaneW-1:0]              lane_q, lane_d;
    logic [CIdxW-1:0]               offset_q, offset_d;
    logic                           pending_q, pending_d;
    logic [CLanes-1:0][CIdxW-1:0]   shadow_q, shadow_d;
    logic [CLanes-1:0][CIdxW-1:0]   snap_q, snap_d;
    logic [CLanes-1:0][CIdxW-1:0]   active_q, active_d;

    logic [CIdxW-1:0]               lane_idx;
    logic                           start_apply;
    logic                           start_scan;
    logic                           scan_tick;
    logic                           timer_en;
    logic                           timer_clr;

    // Timer only runs while idle; an apply-started load restarts the period.
    assign timer_en  = AClkHEn && AScanEn && (state_q == IDLE);
    assign timer_clr = AClkHEn && (!AScanEn || start_apply);

    test_mux_scan_timer #(
        .CTimerW (CTimerW)
    ) u_scan_timer (
        .clk_i    (AClkH),
        .rst_i    (AResetH),
        .en_i     (timer_en),
        .period_i (AScanPeriod),
        .clr_i    (timer_clr),
        .tick_o   (scan_tick)
    );

    assign lane_idx = snap_q[lane_q] + offset_q;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        offset_d    = offset_q;
        pending_d   = pending_q;
        shadow_d    = shadow_q;
        snap_d      = snap_q;
        active_d    = active_q;
        start_apply = 1'b0;
        start_scan  = 1'b0;

        if (ACfgWrEn) begin
            shadow_d[ACfgAddr] = ACfgData;
        end

        unique case (state_q)
            IDLE: begin
                if (AApply) begin
                    start_apply = 1'b1;
                end else if (scan_tick) begin
                    start_scan = 1'b1;
                end
            end
            LOAD: begin
                if (AApply) begin
                    pending_d = 1'b1;
                end
                active_d[lane_q] = lane_idx;
                lane_d           = lane_q + 1'b1;
                if (lane_q == CLaneW'(CLanes - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // An apply landing in the DONE cycle itself is served like a pending one.
                if (pending_q || AApply) begin
                    start_apply = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_apply || start_scan) begin
            state_d   = LOAD;
            lane_d    = '0;
            snap_d    = shadow_q;
            pending_d = 1'b0;
            offset_d  = start_apply ? '0 : offset_q + CIdxW'(CScanStep);
        end
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            offset_q  <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            snap_q    <= '0;
            active_q  <= '0;
        end else if (AClkHEn) begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            offset_q  <= offset_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            snap_q    <= snap_d;
            active_q  <= active_d;
        end
    end

    // Strobes derive from registered state; gating keeps them quiet during hold.
    assign ASelWrEn   = (AClkHEn && state_q == LOAD) ? lane_onehot(lane_q) : '0;
    assign ASelIdx    = (state_q == LOAD) ? lane_idx : '0;
    assign ADone      = AClkHEn && (state_q == DONE);
    assign ABusy      = (state_q != IDLE);
    assign AActiveIdx = active_q;
    assign ADbgState  = state_q;

endmodule

// File: tb/tb_test_mux_sched.sv
// Directed bench for test_mux_sched: table-driven basic load plus hand-written
// sequences for scan, pending apply, snapshot, clock-enable and reset corners.
module tb_test_mux_sched;
    import test_mux_pkg::*;

    localparam int TW = 16;

    logic                    clk = 1'b0;
    logic                    AResetH, AClkHEn, ACfgWrEn, AApply, AScanEn;
    logic [2:0]              ACfgAddr;
    logic [5:0]              ACfgData;
    logic [TW-1:0]           AScanPeriod;
    logic [5:0]              ASelIdx;
    logic [7:0]              ASelWrEn;
    logic [47:0]             AActiveIdx;
    logic                    ABusy, ADone;
    state_e                  ADbgState;

    always #5 clk = ~clk;

    test_mux_sched #(.CTimerW(TW)) dut (
        .AClkH       (clk),
        .AResetH     (AResetH),
        .AClkHEn     (AClkHEn),
        .ACfgWrEn    (ACfgWrEn),
        .ACfgAddr    (ACfgAddr),
        .ACfgData    (ACfgData),
        .AApply      (AApply),
        .AScanEn     (AScanEn),
        .AScanPeriod (AScanPeriod),
        .ASelIdx     (ASelIdx),
        .ASelWrEn    (ASelWrEn),
        .AActiveIdx  (AActiveIdx),
        .ABusy       (ABusy),
        .ADone       (ADone),
        .ADbgState   (ADbgState)
    );

    int checks   = 0;
    int failures = 0;

    logic [5:0]      shadow_m[8];
    logic [7:0][5:0] active_m;
    logic [5:0]      exp_q[$];

    typedef struct {
        logic       apply;
        logic [7:0] wren;
        logic [5:0] idx;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next cycle; outputs are sampled 1 ns after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue_apply();
        step();
        AApply = 1'b1;
        step();
        AApply = 1'b0;
    endtask

    // Waits (bounded) for the lane0 strobe, then checks all eight lanes and ADone.
    task automatic check_load(input logic [5:0] off, output int gap);
        logic [5:0] e;
        gap = 0;
        exp_q.delete();
        for (int l = 0; l < 8; l++) begin
            e = shadow_m[l] + off;
            exp_q.push_back(e);
        end
        while (ASelWrEn !== 8'h01 && gap < 60) begin
            step();
            gap++;
        end
        chk("lane0_start", ASelWrEn, 8'h01);
        if (ASelWrEn === 8'h01) begin
            for (int l = 0; l < 8; l++) begin
                if (l > 0) step();
                e = exp_q.pop_front();
                chk($sformatf("lane%0d_strobe", l), ASelWrEn, 8'(1) << l);
                chk($sformatf("lane%0d_idx", l), ASelIdx, e);
                active_m[l] = e;
            end
            step();
            chk("load_done", ADone, 1'b1);
            chk("load_active", AActiveIdx, active_m);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap;
        int strobes, lane0_cnt, done_cnt, done1, done2, busy_late, viol;
        int lane_cnt[8];

        AResetH = 1'b1; AClkHEn = 1'b1; ACfgWrEn = 1'b0; ACfgAddr = '0;
        ACfgData = '0; AApply = 1'b0; AScanEn = 1'b0; AScanPeriod = '0;
        active_m = '0;
        for (int l = 0; l < 8; l++) shadow_m[l] = '0;

        vt[0]  = '{1'b1, 8'h00, 6'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 8'h01, 6'd0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 8'h02, 6'd1, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 8'h04, 6'd2, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 8'h08, 6'd3, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 8'h10, 6'd4, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 8'h20, 6'd5, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 8'h40, 6'd6, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 8'h80, 6'd7, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 6'd0, 1'b1, 1'b1};
        vt[10] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        step();
        AResetH = 1'b0;
        chk("rst_wren", ASelWrEn, 8'h00);
        chk("rst_idx", ASelIdx, 6'd0);
        chk("rst_active", AActiveIdx, 48'h0);
        chk("rst_busy", ABusy, 1'b0);
        chk("rst_done", ADone, 1'b0);
        chk("rst_state", ADbgState, IDLE);

        // Shadow = lane i -> source i, then table-driven apply sequence
        for (int l = 0; l < 8; l++) begin
            step();
            ACfgWrEn = 1'b1; ACfgAddr = 3'(l); ACfgData = 6'(l);
            shadow_m[l] = 6'(l);
        end
        step();
        ACfgWrEn = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            AApply = vt[i].apply;
            chk($sformatf("t1_wren[%0d]", i), ASelWrEn, vt[i].wren);
            chk($sformatf("t1_busy[%0d]", i), ABusy, vt[i].busy);
            chk($sformatf("t1_done[%0d]", i), ADone, vt[i].done);
            if (vt[i].wren != 8'h00) chk($sformatf("t1_idx[%0d]", i), ASelIdx, vt[i].idx);
        end
        for (int l = 0; l < 8; l++) active_m[l] = shadow_m[l];
        chk("t1_active", AActiveIdx, active_m);

        // Auto-scan with period 4: offsets 8,16,...,56 then wrap to 0
        AScanPeriod = 16'd4;
        AScanEn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check_load(6'((8 * k) % 64), gap);
            chk($sformatf("scan_gap%0d", k), gap, (k == 1) ? 4 : 5);
        end
        AScanEn = 1'b0;

        // Apply during lane 3 plus a merged second request: exactly one extra load
        strobes = 0; lane0_cnt = 0; done_cnt = 0; done1 = -1; done2 = -1; busy_late = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            AApply = (c == 0 || c == 4 || c == 6);
            strobes += $countones(ASelWrEn);
            if (ASelWrEn == 8'h01) lane0_cnt++;
            if (ADone) begin
                done_cnt++;
                if (done_cnt == 1) done1 = c;
                if (done_cnt == 2) done2 = c;
            end
            if (c >= 19 && ABusy) busy_late++;
        end
        AApply = 1'b0;
        chk("pend_lane0_cnt", lane0_cnt, 2);
        chk("pend_strobes", strobes, 16);
        chk("pend_done_cnt", done_cnt, 2);
        chk("pend_done1_cycle", done1, 9);
        chk("pend_done2_cycle", done2, 18);
        chk("pend_idle_after", busy_late, 0);
        chk("pend_active", AActiveIdx, active_m);

        // Shadow write during LOAD only visible at the next load
        for (int c = 0; c < 10; c++) begin
            step();
            AApply = (c == 0);
            ACfgWrEn = (c == 2); ACfgAddr = 3'd5; ACfgData = 6'd63;
            if (c == 6) begin
                chk("snap_lane5_strobe", ASelWrEn, 8'h20);
                chk("snap_lane5_old", ASelIdx, 6'd5);
            end
        end
        ACfgWrEn = 1'b0;
        shadow_m[5] = 6'd63;
        issue_apply();
        check_load(6'd0, gap);
        AScanEn = 1'b1;
        check_load(6'd8, gap);
        AScanEn = 1'b0;
        chk("snap_lane5_scan", active_m[5], 6'd7);

        // Clock enable toggling during LOAD
        step();
        AApply = 1'b1;
        viol = 0; strobes = 0; done_cnt = 0;
        for (int l = 0; l < 8; l++) lane_cnt[l] = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            AApply = 1'b0;
            AClkHEn = (c % 2 == 1);
            #1;
            if (!AClkHEn && (ASelWrEn != 8'h00 || ADone)) viol++;
            strobes += $countones(ASelWrEn);
            for (int l = 0; l < 8; l++) if (ASelWrEn[l]) lane_cnt[l]++;
            if (ADone) done_cnt++;
        end
        AClkHEn = 1'b1;
        chk("ce_hold_quiet", viol, 0);
        chk("ce_strobes", strobes, 8);
        chk("ce_done_cnt", done_cnt, 1);
        for (int l = 0; l < 8; l++) chk($sformatf("ce_lane%0d_once", l), lane_cnt[l], 1);
        for (int l = 0; l < 8; l++) active_m[l] = shadow_m[l];
        chk("ce_active", AActiveIdx, active_m);

        // Reset at lane 4 aborts the sequence
        step();
        AApply = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            AApply = 1'b0;
            if (c == 5) begin
                chk("rst_mid_lane4", ASelWrEn, 8'h10);
                AResetH = 1'b1;
            end
        end
        step();
        AResetH = 1'b0;
        chk("rst_mid_wren", ASelWrEn, 8'h00);
        chk("rst_mid_idx", ASelIdx, 6'd0);
        chk("rst_mid_active", AActiveIdx, 48'h0);
        chk("rst_mid_busy", ABusy, 1'b0);
        chk("rst_mid_done", ADone, 1'b0);
        chk("rst_mid_state", ADbgState, IDLE);
        for (int l = 0; l < 8; l++) shadow_m[l] = '0;
        active_m = '0;

        // Period 0 with scan enabled never ticks
        AScanEn = 1'b1;
        AScanPeriod = '0;
        viol = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (ASelWrEn != 8'h00 || ABusy) viol++;
        end
        AScanEn = 1'b0;
        chk("period0_no_tick", viol, 0);

        issue_apply();
        check_load(6'd0, gap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
